// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
// No logic of its own; imported by the decoder and the top.
// No flow control lives here.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

    // Slot counter width; never below 1 bit so single-bit ports stay legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_decoder.sv
// Slot index plus enable to one-hot lane write-enable (inverse of the mux select).
// Combinational, zero latency.
// No backpressure: pure decode.
module tdm_slot_decoder
    import tdm_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = cnt_width(N)
) (
    input  logic [SW-1:0] slot,
    input  logic          en,
    output logic [N-1:0]  we
);

    always_comb begin
        we = '0;
        // Out-of-range slots (non power-of-two N) decode to nothing.
        if (en && (int'(slot) < N)) begin
            we[slot] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Frame-locked TDM demultiplexer: fans one interleaved word stream out to N lanes.
// Latency 1: a word accepted at edge t is on its lane after edge t.
// No backpressure: every valid word is consumed or dropped the cycle it arrives.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           up_valid,
    input  logic           up_first,
    input  logic [W-1:0]   up_data,
    output logic [N-1:0]   down_valid,
    output logic [N*W-1:0] down_data,
    output logic           frame_done,
    output logic           locked,
    output logic           sync_err
);

    localparam int SW = cnt_width(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);
    localparam logic [SW-1:0] ONE  = SW'(1);

    tdm_state_t           state, state_nxt;
    logic [SW-1:0]        cnt, cnt_nxt;
    logic                 wr_en;
    logic [SW-1:0]        wr_slot;
    logic                 err_nxt;
    logic                 done_nxt;
    logic [N-1:0]         we;
    logic [N-1:0][W-1:0]  lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        wr_slot   = '0;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        if (up_valid) begin
            unique case (state)
                HUNT: begin
                    // Anything before the first frame start is discarded silently.
                    if (up_first) begin
                        wr_en     = 1'b1;
                        cnt_nxt   = ONE;
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (up_first) begin
                        // Early frame start resyncs onto the new frame.
                        err_nxt = (cnt != '0);
                        wr_en   = 1'b1;
                        cnt_nxt = ONE;
                    end else if (cnt == '0) begin
                        err_nxt   = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        wr_en   = 1'b1;
                        wr_slot = cnt;
                        if (cnt == LAST) begin
                            cnt_nxt  = '0;
                            done_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    tdm_slot_decoder #(
        .N  (N),
        .SW (SW)
    ) u_dec (
        .slot (wr_slot),
        .en   (wr_en),
        .we   (we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lane       <= '0;
            down_valid <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (we[k]) begin
                    lane[k] <= up_data;
                end
            end
            down_valid <= we;
            frame_done <= done_nxt;
            sync_err   <= err_nxt;
            locked     <= (state_nxt == LOCKED);
        end
    end

    assign down_data = lane;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (N=4, W=8): driver pushes expected outputs,
// monitor pops one entry per cycle, 1 ns after each rising edge.
module tb_tdm_demux;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           up_valid;
    logic           up_first;
    logic [W-1:0]   up_data;
    logic [N-1:0]   down_valid;
    logic [N*W-1:0] down_data;
    logic           frame_done;
    logic           locked;
    logic           sync_err;

    typedef struct {
        logic [N-1:0]   dv;
        logic [N*W-1:0] dd;
        logic           fd;
        logic           err;
        logic           lk;
    } exp_t;

    exp_t           sb_q[$];
    logic [W-1:0]   shadow[N];
    int             n_chk = 0;
    int             n_err = 0;

    always #5 clk = ~clk;

    tdm_demux #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_first   (up_first),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_data  (down_data),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Drives one cycle of stimulus and pushes what must appear after the next edge.
    // lane < 0 means the word must produce no lane write.
    task automatic drive(input logic r, input logic v, input logic f, input logic [W-1:0] d,
                         input int lane, input logic err, input logic fd, input logic lk);
        exp_t e;
        rst      = r;
        up_valid = v;
        up_first = f;
        up_data  = d;
        if (r) begin
            for (int k = 0; k < N; k++) shadow[k] = '0;
        end else if (lane >= 0) begin
            shadow[lane] = d;
        end
        e.dv  = (!r && lane >= 0) ? N'(1 << lane) : '0;
        for (int k = 0; k < N; k++) e.dd[k*W +: W] = shadow[k];
        e.fd  = r ? 1'b0 : fd;
        e.err = r ? 1'b0 : err;
        e.lk  = r ? 1'b0 : lk;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic lk);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, -1, 1'b0, 1'b0, lk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("down_valid", 32'(down_valid), 32'(e.dv));
            chk("down_data",  32'(down_data),  32'(e.dd));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
            chk("sync_err",   32'(sync_err),   32'(e.err));
            chk("locked",     32'(locked),     32'(e.lk));
        end
    end

    initial begin
        logic [W-1:0] rd;
        for (int k = 0; k < N; k++) shadow[k] = '0;

        // Reset, idle, then unframed words are dropped quietly.
        drive(1'b1, 1'b0, 1'b0, 8'h00, -1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, -1, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h11, -1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h22, -1, 1'b0, 1'b0, 1'b0);

        // Back-to-back frame acquires lock.
        drive(1'b0, 1'b1, 1'b1, 8'hA0, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'hB1, 1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'hC2, 2, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'hD3, 3, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);
        chk("frame_a_lanes", 32'(down_data), 32'hD3C2B1A0);

        // Same frame with two-cycle gaps between words.
        drive(1'b0, 1'b1, 1'b1, 8'hA0, 0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'hB1, 1, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'hC2, 2, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'hD3, 3, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);

        // Early frame start at counter 2 resyncs.
        drive(1'b0, 1'b1, 1'b1, 8'h01, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h02, 1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 8'h55, 0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h03, 1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h04, 2, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h05, 3, 1'b0, 1'b1, 1'b1);

        // Missing frame start at counter 0 drops lock; next first word reacquires.
        drive(1'b0, 1'b1, 1'b0, 8'h77, -1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h88, -1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h99, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h9A, 1, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame with a word present; follow-on words are dropped.
        drive(1'b1, 1'b1, 1'b0, 8'hAB, -1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'hCD, -1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'hEF, -1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Random-data frames with random gaps.
        for (int fr = 0; fr < 6; fr++) begin
            for (int s = 0; s < N; s++) begin
                rd = W'($urandom_range(0, 255));
                drive(1'b0, 1'b1, (s == 0), rd, s, 1'b0, (s == N - 1), 1'b1);
                if ($urandom_range(0, 2) == 0) idle(1, 1'b1);
            end
        end
        idle(3, 1'b1);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: receives one word stream carrying N interleaved channels (channel 0 marked by a frame-start flag) and fans each word out to its own registered output lane.
- Receiving end of the team's round-robin serializing mux; sits between a shared link and N independent per-channel consumers.
- Frame-lock state machine: acquires frame alignment, tracks the channel slot, and reports loss of sync.

Parameters:
- N, 4, number of channels; legal range N >= 2
- W, 8, data width per word, in bits

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- up_valid  input  1  word present on up_data this cycle
- up_first  input  1  word on up_data is channel 0 (frame start); ignored when up_valid=0
- up_data  input  W  incoming word
- down_valid  output  N  bit k: one-cycle pulse, lane k updated this cycle
- down_data  output  N*W  lane k occupies bits [k*W +: W]; each lane holds its last written word
- frame_done  output  1  one-cycle pulse, channel N-1 word delivered
- locked  output  1  state is LOCKED
- sync_err  output  1  one-cycle pulse, framing violation detected

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=HUNT, slot counter=0, down_valid=0, down_data=0, frame_done=0, locked=0, sync_err=0. Reset overrides any word accepted in the same cycle. Reset mid-frame discards partial-frame progress; lanes clear to 0.
- Slot counter width: $clog2(N). Wraps from N-1 to 0.
- All outputs are registered. A word accepted at edge t appears on its lane with its down_valid bit high in the cycle after edge t (latency 1). At most one down_valid bit is high per cycle.
- up_valid=0 cycles: no state change; the counter is held. Gaps inside a frame are legal.
- HUNT state:
  - up_valid && !up_first: word dropped, no output activity, no sync_err.
  - up_valid && up_first: word written to lane 0, counter=1, go to LOCKED.
- LOCKED state, up_valid=1:
  - Counter=c != 0 and !up_first: word written to lane c. If c==N-1, counter=0 and frame_done pulses with down_valid[N-1]. Otherwise counter=c+1.
  - Counter=0 and up_first: word written to lane 0, counter=1.
  - Counter != 0 and up_first (early frame start): sync_err pulses. Resync: word written to lane 0, counter=1, stay LOCKED. No frame_done for the truncated frame.
  - Counter=0 and !up_first (missing frame start): sync_err pulses, word dropped, go to HUNT, locked deasserts next cycle.
- locked equals (state==LOCKED), registered. It asserts in the same cycle as the lane-0 down_valid for the acquiring word.
- Lanes not addressed in a cycle keep their value.

Decomposition:
- Shared package tdm_pkg:
  - typedef enum logic {HUNT, LOCKED} tdm_state_t
  - function for counter width
- One sub-module: tdm_slot_decoder (combinational): slot index plus enable in, N-bit one-hot write-enable out. It is the inverse of the mux select path. The main module instantiates it once and owns the state machine, counter, and lane registers.

Test Plan (N=4, W=8):
- Reset, then idle -> all outputs 0, locked=0 for 5 cycles. Words 8'h11 and 8'h22 sent without up_first -> dropped, no down_valid, no sync_err.
- Frame A0,B1,C2,D3 with up_first on A0, back-to-back -> down_valid = 0001,0010,0100,1000 on consecutive cycles, each 1 cycle after its input. down_data = 32'hD3C2B1A0. frame_done pulses with 1000. locked=1 from the first output cycle.
- Same frame with 2-cycle up_valid=0 gaps between words -> identical lane contents, pulses delayed accordingly, counter held across gaps.
- Locked, after 8'h01 and 8'h02 (counter=2), send 8'h55 with up_first -> sync_err pulse, lane0=8'h55, down_valid=0001. Next 3 words land on lanes 1..3, then frame_done.
- Locked at counter=0, send 8'h77 without up_first -> sync_err pulse, no down_valid, locked=0 the next cycle. The next up_first word reacquires lock on lane 0.
- Assert rst mid-frame (counter=2) while up_valid=1 -> no down_valid that cycle, all lanes 0, state HUNT. The following non-first words are dropped.
